// File: rtl/food_pkg.sv
// Shared types for the food flush engine: FSM state encoding and default playfield size.
// Pure declarations; no timing or flow-control behaviour lives here.
package food_pkg;

  localparam int DEF_COLS = 80;
  localparam int DEF_ROWS = 64;

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_RD,
    S_WAIT,
    S_CHK,
    S_WR
  } state_t;

endpackage

// File: rtl/food_row_ram.sv
// Dual-port row RAM: port A read/write, port B read-only, both 1-cycle read latency.
// Read-first on both ports, so a same-cycle write is seen by the next read. No backpressure.
module food_row_ram #(
  parameter int W  = 80,
  parameter int D  = 64,
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [W-1:0]  a_wdat,
  output logic [W-1:0]  a_rdat,
  input  logic [AW-1:0] b_addr,
  output logic [W-1:0]  b_rdat
);

  logic [W-1:0] mem [D];
  logic [W-1:0] a_rdat_q;
  logic [W-1:0] b_rdat_q;

  always_ff @(posedge clk) begin
    if (a_we) begin
      mem[a_addr] <= a_wdat;
    end
    a_rdat_q <= mem[a_addr];
    b_rdat_q <= mem[b_addr];
  end

  assign a_rdat = a_rdat_q;
  assign b_rdat = b_rdat_q;

endmodule

// File: rtl/food_flush_engine.sv
// Pellet engine: INIT fills every row, then each tick runs one pass of at most 4 cycles per eater.
// One tick queues while busy; further ticks drop with tick_overrun. FOOD_SCORE_EN adds a saturating score.
module food_flush_engine
  import food_pkg::*;
#(
  parameter int              COLS     = DEF_COLS,
  parameter int              ROWS     = DEF_ROWS,
  parameter int              N_EATERS = 1,
  parameter logic [COLS-1:0] INIT_ROW = {COLS{1'b1}},
  localparam int             XW       = $clog2(COLS),
  localparam int             YW       = $clog2(ROWS),
  localparam int             CW       = $clog2(COLS*ROWS+1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   tick,
  input  logic [N_EATERS*XW-1:0] eat_x,
  input  logic [N_EATERS*YW-1:0] eat_y,
  input  logic [YW-1:0]          rd_y,
  output logic [COLS-1:0]        rd_row,
  output logic [N_EATERS-1:0]    eaten,
  output logic [CW-1:0]          food_left,
  output logic                   level_clear,
  output logic                   busy,
`ifdef FOOD_SCORE_EN
  output logic [15:0]            score,
`endif
  output logic                   tick_overrun
);

  function automatic int popcnt(logic [COLS-1:0] v);
    int n;
    n = 0;
    for (int k = 0; k < COLS; k++) n += int'(v[k]);
    return n;
  endfunction

  localparam int            IW   = (N_EATERS > 1) ? $clog2(N_EATERS) : 1;
  localparam logic [CW-1:0] FULL = CW'(popcnt(INIT_ROW) * ROWS);

  state_t                   state_q, state_d;
  logic [IW-1:0]            idx_q, idx_d;
  logic [YW-1:0]            init_row_q, init_row_d;
  logic                     pend_q, pend_d;
  logic [N_EATERS*XW-1:0]   ex_q, ex_d;
  logic [N_EATERS*YW-1:0]   ey_q, ey_d;
  logic [N_EATERS-1:0]      eaten_q, eaten_d;
  logic                     ovr_q, ovr_d;
  logic [CW-1:0]            food_q, food_d;
  logic [COLS-1:0]          wr_row_q, wr_row_d;

  logic [XW-1:0]            cur_x;
  logic [YW-1:0]            cur_y;
  logic                     cur_skip;
  logic                     adv;
  logic                     a_we;
  logic [YW-1:0]            a_addr;
  logic [COLS-1:0]          a_wdat;
  logic [COLS-1:0]          a_rdat;

  food_row_ram #(
    .W  (COLS),
    .D  (ROWS),
    .AW (YW)
  ) u_ram (
    .clk    (clk),
    .a_we   (a_we && !reset),
    .a_addr (a_addr),
    .a_wdat (a_wdat),
    .a_rdat (a_rdat),
    .b_addr (rd_y),
    .b_rdat (rd_row)
  );

  always_comb begin
    cur_x    = ex_q[int'(idx_q)*XW +: XW];
    cur_y    = ey_q[int'(idx_q)*YW +: YW];
    cur_skip = (int'(cur_x) >= COLS) || (int'(cur_y) >= ROWS);
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    init_row_d = init_row_q;
    pend_d     = pend_q;
    ex_d       = ex_q;
    ey_d       = ey_q;
    eaten_d    = '0;
    ovr_d      = 1'b0;
    food_d     = food_q;
    wr_row_d   = wr_row_q;
    adv        = 1'b0;
    a_we       = 1'b0;
    a_addr     = cur_y;
    a_wdat     = wr_row_q;

    case (state_q)
      S_INIT: begin
        a_we       = 1'b1;
        a_addr     = init_row_q;
        a_wdat     = INIT_ROW;
        init_row_d = init_row_q + 1'b1;
        if (int'(init_row_q) == ROWS-1) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (tick || pend_q) begin
          state_d = S_RD;
          idx_d   = '0;
          ex_d    = eat_x;
          ey_d    = eat_y;
          // A pending tick is consumed here; a fresh tick on the same cycle re-arms it.
          pend_d  = tick && pend_q;
        end
      end
      S_RD: begin
        if (cur_skip) adv = 1'b1;
        else          state_d = S_WAIT;
      end
      S_WAIT: state_d = S_CHK;
      S_CHK: begin
        if (a_rdat[cur_x]) begin
          wr_row_d       = a_rdat & ~(COLS'(1) << cur_x);
          eaten_d[idx_q] = 1'b1;
          food_d         = (food_q == '0) ? '0 : food_q - 1'b1;
          state_d        = S_WR;
        end else begin
          adv = 1'b1;
        end
      end
      S_WR: begin
        a_we = 1'b1;
        adv  = 1'b1;
      end
      default: state_d = S_INIT;
    endcase

    if (adv) begin
      if (int'(idx_q) == N_EATERS-1) begin
        state_d = S_IDLE;
      end else begin
        idx_d   = idx_q + 1'b1;
        state_d = S_RD;
      end
    end

    if (tick && state_q != S_IDLE) begin
      if (pend_q) ovr_d  = 1'b1;
      else        pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_INIT;
      idx_q      <= '0;
      init_row_q <= '0;
      pend_q     <= 1'b0;
      ex_q       <= '0;
      ey_q       <= '0;
      eaten_q    <= '0;
      ovr_q      <= 1'b0;
      food_q     <= FULL;
      wr_row_q   <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      init_row_q <= init_row_d;
      pend_q     <= pend_d;
      ex_q       <= ex_d;
      ey_q       <= ey_d;
      eaten_q    <= eaten_d;
      ovr_q      <= ovr_d;
      food_q     <= food_d;
      wr_row_q   <= wr_row_d;
    end
  end

  assign eaten        = eaten_q;
  assign tick_overrun = ovr_q;
  assign food_left    = food_q;
  assign busy         = (state_q != S_IDLE);
  assign level_clear  = (food_q == '0) && (state_q != S_INIT);

`ifdef FOOD_SCORE_EN
  logic [15:0] score_q, score_d;
  logic [16:0] score_sum;

  always_comb begin
    score_sum = {1'b0, score_q};
    for (int k = 0; k < N_EATERS; k++) score_sum = score_sum + 17'(eaten_q[k]);
    score_d = score_sum[16] ? 16'hFFFF : score_sum[15:0];
  end

  always_ff @(posedge clk) begin
    if (reset) score_q <= '0;
    else       score_q <= score_d;
  end

  assign score = score_q;
`endif

endmodule

// File: tb/tb_food_flush_engine.sv
// Directed bench: three engine instances (80x64 single eater, 80x64 dual eater, 6x4 sparse row).
module tb_food_flush_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Instance A: 80x64, one eater
  logic        a_reset, a_tick, a_lc, a_busy, a_ovr;
  logic [6:0]  a_ex;
  logic [5:0]  a_ey, a_rdy;
  logic [79:0] a_row;
  logic [0:0]  a_eaten;
  logic [12:0] a_food;
  // Instance B: 80x64, two eaters
  logic        o_reset;
  logic        b_tick, b_lc, b_busy, b_ovr;
  logic [13:0] b_ex;
  logic [11:0] b_ey;
  logic [5:0]  b_rdy;
  logic [79:0] b_row;
  logic [1:0]  b_eaten;
  logic [12:0] b_food;
  // Instance C: 6x4, single pellet per row at column 2
  logic        c_tick, c_lc, c_busy, c_ovr;
  logic [2:0]  c_ex;
  logic [1:0]  c_ey, c_rdy;
  logic [5:0]  c_row;
  logic [0:0]  c_eaten;
  logic [4:0]  c_food;
`ifdef FOOD_SCORE_EN
  logic [15:0] a_score, b_score, c_score;
`endif

  food_flush_engine #(.COLS(80), .ROWS(64), .N_EATERS(1)) u_a (
    .clk(clk), .reset(a_reset), .tick(a_tick), .eat_x(a_ex), .eat_y(a_ey),
    .rd_y(a_rdy), .rd_row(a_row), .eaten(a_eaten), .food_left(a_food),
    .level_clear(a_lc), .busy(a_busy),
`ifdef FOOD_SCORE_EN
    .score(a_score),
`endif
    .tick_overrun(a_ovr));

  food_flush_engine #(.COLS(80), .ROWS(64), .N_EATERS(2)) u_b (
    .clk(clk), .reset(o_reset), .tick(b_tick), .eat_x(b_ex), .eat_y(b_ey),
    .rd_y(b_rdy), .rd_row(b_row), .eaten(b_eaten), .food_left(b_food),
    .level_clear(b_lc), .busy(b_busy),
`ifdef FOOD_SCORE_EN
    .score(b_score),
`endif
    .tick_overrun(b_ovr));

  food_flush_engine #(.COLS(6), .ROWS(4), .N_EATERS(1), .INIT_ROW(6'b000100)) u_c (
    .clk(clk), .reset(o_reset), .tick(c_tick), .eat_x(c_ex), .eat_y(c_ey),
    .rd_y(c_rdy), .rd_row(c_row), .eaten(c_eaten), .food_left(c_food),
    .level_clear(c_lc), .busy(c_busy),
`ifdef FOOD_SCORE_EN
    .score(c_score),
`endif
    .tick_overrun(c_ovr));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          n;
    int          ec;
    int          e1;
    logic [1:0]  eor;
    logic [79:0] exp_row;
    logic [1:0]  ys [3];

    a_reset = 1'b1; o_reset = 1'b1;
    a_tick = 1'b0; b_tick = 1'b0; c_tick = 1'b0;
    a_ex = '0; a_ey = '0; b_ex = '0; b_ey = '0; c_ex = '0; c_ey = '0;
    a_rdy = '0; b_rdy = '0; c_rdy = '0;
    step; step;
    a_reset = 1'b0; o_reset = 1'b0;

    chk("rst_busy", a_busy, 1);
    chk("rst_level_clear", a_lc, 0);
    chk("rst_food", a_food, 5120);
    chk("rst_overrun", a_ovr, 0);
    chk("rst_eaten", a_eaten, 0);

    n = 0;
    while (a_busy && n < 200) begin step; n++; end
    chk("init_cycles", n, 64);
    chk("idle_food", a_food, 5120);
    chk("idle_level_clear", a_lc, 0);
    a_rdy = 6'd5; step;
    chk("row5_full", a_row, {80{1'b1}});

    // Single eater at (3,7)
    a_ex = 7'd3; a_ey = 6'd7; a_tick = 1'b1; step; a_tick = 1'b0;
    ec = 0;
    for (int k = 0; k < 10; k++) begin if (a_eaten[0]) ec++; step; end
    chk("eat1_pulses", ec, 1);
    chk("eat1_food", a_food, 5119);
    a_rdy = 6'd7; step;
    exp_row = {80{1'b1}}; exp_row[3] = 1'b0;
    chk("row7_bit3_cleared", a_row, exp_row);

    // Same cell again: already empty
    a_tick = 1'b1; step; a_tick = 1'b0;
    ec = 0;
    for (int k = 0; k < 10; k++) begin if (a_eaten[0]) ec++; step; end
    chk("eat2_pulses", ec, 0);
    chk("eat2_food", a_food, 5119);

    // Ticks on three consecutive cycles: start, queue, drop
    a_ex = 7'd20; a_ey = 6'd9; a_tick = 1'b1; step;
    a_ex = 7'd21; step;
    step;
    a_tick = 1'b0;
    chk("overrun_pulse", a_ovr, 1);
    step;
    chk("overrun_one_cycle", a_ovr, 0);
    ec = int'(a_eaten[0]);
    for (int k = 0; k < 20; k++) begin step; if (a_eaten[0]) ec++; end
    chk("queued_pass_pulses", ec, 2);
    chk("queued_pass_food", a_food, 5117);
    chk("queued_pass_idle", a_busy, 0);
    a_rdy = 6'd9; step;
    exp_row = {80{1'b1}}; exp_row[20] = 1'b0; exp_row[21] = 1'b0;
    chk("row9_two_cleared", a_row, exp_row);

    // Two eaters on one cell
    b_ex = {7'd10, 7'd10}; b_ey = {6'd2, 6'd2}; b_tick = 1'b1; step; b_tick = 1'b0;
    eor = '0; ec = 0; e1 = 0;
    for (int k = 0; k < 14; k++) begin
      eor = eor | b_eaten;
      if (b_eaten[0]) ec++;
      if (b_eaten[1]) e1++;
      step;
    end
    chk("dual_eaten_or", eor, 2'b01);
    chk("dual_e0_pulses", ec, 1);
    chk("dual_e1_pulses", e1, 0);
    chk("dual_food", b_food, 5119);

    // Small playfield: out-of-range eater is skipped
    chk("c_init_food", c_food, 4);
    chk("c_init_level_clear", c_lc, 0);
    c_ex = 3'd6; c_ey = 2'd0; c_tick = 1'b1; step; c_tick = 1'b0;
    n = 0; ec = 0;
    while (c_busy && n < 20) begin if (c_eaten[0]) ec++; step; n++; end
    chk("skip_cycles", n, 1);
    chk("skip_pulses", ec, 0);
    chk("skip_food", c_food, 4);

    // Eat (2,1) while display reads row 1: read-first on the write cycle
    c_rdy = 2'd1; c_ex = 3'd2; c_ey = 2'd1; c_tick = 1'b1; step; c_tick = 1'b0;
    n = 0;
    while (c_busy && n < 20) begin step; n++; end
    chk("pass_cycles", n, 4);
    chk("read_first_old", c_row, 6'b000100);
    step;
    chk("read_first_new", c_row, 6'b000000);

    ys[0] = 2'd0; ys[1] = 2'd2; ys[2] = 2'd3;
    for (int j = 0; j < 3; j++) begin
      c_ey = ys[j]; c_tick = 1'b1; step; c_tick = 1'b0;
      n = 0;
      while (c_busy && n < 20) begin step; n++; end
    end
    chk("clear_food", c_food, 0);
    chk("clear_level", c_lc, 1);

    // Eating an empty cell with food at zero stays at zero
    c_ey = 2'd0; c_tick = 1'b1; step; c_tick = 1'b0;
    for (int k = 0; k < 8; k++) step;
    chk("sat_food", c_food, 0);

    // Reset while the pass sits in WAIT
    a_ex = 7'd30; a_ey = 6'd11; a_tick = 1'b1; step; a_tick = 1'b0;
    step;
    a_reset = 1'b1; step; a_reset = 1'b0;
    chk("midpass_rst_food", a_food, 5120);
    chk("midpass_rst_busy", a_busy, 1);
    chk("midpass_rst_level_clear", a_lc, 0);
    chk("midpass_rst_eaten", a_eaten, 0);
    n = 0;
    while (a_busy && n < 200) begin step; n++; end
    chk("reinit_cycles", n, 64);
    a_rdy = 6'd11; step;
    chk("row11_full", a_row, {80{1'b1}});
    a_rdy = 6'd7; step;
    chk("row7_restored", a_row, {80{1'b1}});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/food_flush_engine.md
FOOD_FLUSH_ENGINE -- requirements
Module: food_flush_engine

Interface
REQ-001 SHALL have parameter COLS, default 80, food columns per row (RAM word width).
REQ-002 SHALL have parameter ROWS, default 64, food rows (RAM depth).
REQ-003 SHALL have parameter N_EATERS, default 1, range 1..4, number of independent eater positions.
REQ-004 SHALL have parameter INIT_ROW, default all-ones [COLS-1:0], pattern loaded into every row at reset.
REQ-005 SHALL have derived localparams XW=$clog2(COLS), YW=$clog2(ROWS), CW=$clog2(COLS*ROWS+1).
REQ-006 clk  in  1  single clock; all logic on posedge; reset is synchronous and active-high.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 tick  in  1  one-cycle game-step strobe; starts one flush pass.
REQ-009 eat_x  in  N_EATERS*XW  packed eater column indices, eater 0 in LSBs.
REQ-010 eat_y  in  N_EATERS*YW  packed eater row indices, eater 0 in LSBs.
REQ-011 rd_y  in  YW  display read row address.
REQ-012 rd_row  out  COLS  display row data, 1-cycle latency after rd_y.
REQ-013 eaten  out  N_EATERS  per-eater one-cycle pulse: pellet removed at that eater's cell.
REQ-014 food_left  out  CW  pellets remaining.
REQ-015 level_clear  out  1  high while food_left==0 and not initialising.
REQ-016 busy  out  1  high during INIT or an active pass.
REQ-017 tick_overrun  out  1  one-cycle pulse when a tick is dropped.

Function
REQ-018 FSM states SHALL be INIT, IDLE, RD, WAIT, CHK, WR.
REQ-019 INIT SHALL write INIT_ROW to rows 0..ROWS-1, one row per cycle (ROWS cycles), then go to IDLE; food_left loaded with popcount(INIT_ROW)*ROWS.
REQ-020 IDLE->RD on tick or pending tick, eater index i=0; eat_x/eat_y for all eaters SHALL be sampled into registers at that transition.
REQ-021 RD drives port-A address eat_y[i]; WAIT covers 1-cycle RAM latency; CHK tests bit eat_x[i] of the returned row.
REQ-022 CHK with bit=1 SHALL go to WR: write row with that bit cleared, pulse eaten[i] the same cycle, decrement food_left by 1.
REQ-023 CHK with bit=0 SHALL skip WR, no pulse, no write.
REQ-024 After CHK/WR, i<N_EATERS-1 -> RD with i+1; else -> IDLE; a pass SHALL take at most 4*N_EATERS cycles.
REQ-025 Eater with eat_x>=COLS or eat_y>=ROWS SHALL be skipped (RD->next directly), no RAM access.
REQ-026 Two eaters on the same cell in one pass: only the lower index SHALL see eaten; the higher reads the already-cleared row.
REQ-027 tick while busy SHALL set a 1-deep pending flag; tick while pending already set SHALL be dropped and pulse tick_overrun.
REQ-028 Port B SHALL be read-only, read-first: a same-cycle port-A write to rd_y SHALL return the old row, new row on the next read.
REQ-029 food_left SHALL saturate at 0 and never underflow.

Reset
REQ-030 reset SHALL enter INIT, clear pending, i, eaten, tick_overrun; busy=1, level_clear=0 during INIT.
REQ-031 reset asserted mid-pass SHALL abort the pass without completing any write and restart INIT.
REQ-032 rd_row SHALL be undefined (don't care) during INIT; verification SHALL not check it there.

Configuration
REQ-033 With FOOD_SCORE_EN defined, output score [15:0] SHALL exist, reset to 0, +1 per eaten bit set each cycle, saturating at 16'hFFFF.
REQ-034 Without FOOD_SCORE_EN, the score port and counter SHALL be absent; all other behaviour identical.

Structure
REQ-035 Shared package food_pkg SHALL hold the FSM state enum and default COLS/ROWS constants.
REQ-036 RAM SHALL be sub-module food_row_ram (true dual-port, port A R/W, port B read, 1-cycle latency, read-first), inferable, no vendor IP.

Verification
REQ-037 Reset, COLS=80 ROWS=64 -> busy 64 cycles, food_left=5120, level_clear=0, rd_y=5 returns all-ones.
REQ-038 N_EATERS=1, eater (3,7), tick -> eaten[0] pulse once, food_left=5119, row 7 bit 3 = 0; second tick same cell -> no pulse.
REQ-039 N_EATERS=2, both at (10,2), tick -> eaten=2'b01 only, food_left decrements by 1.
REQ-040 Ticks on cycles t, t+1, t+2 during a pass -> one pass queued, tick_overrun pulse at t+2.
REQ-041 INIT_ROW with 1 bit set, ROWS=4, eat all 4 pellets -> food_left=0, level_clear=1; eater at x=COLS -> skipped, no change.
REQ-042 Reset asserted during WAIT -> no write lands, INIT reruns, food_left restored to full.
